// File: rtl/rom_arbiter_if.sv
// Request/response bundle between the IFU/LSU requesters, the ROM arbiter and the
// instruction ROM.
interface rom_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_valid;
  logic [XLEN-1:0] if_data;
  logic            ls_req;
  logic [XLEN-1:0] ls_addr;
  logic            ls_gnt;
  logic            ls_valid;
  logic [XLEN-1:0] ls_data;
  logic            flush;
  logic [XLEN-1:0] rom_addr;
  logic [XLEN-1:0] rom_data;

  modport master (
    output if_req, if_addr, ls_req, ls_addr, flush, rom_data,
    input  if_gnt, if_valid, if_data, ls_gnt, ls_valid, ls_data, rom_addr
  );

  modport slave (
    input  if_req, if_addr, ls_req, ls_addr, flush, rom_data,
    output if_gnt, if_valid, if_data, ls_gnt, ls_valid, ls_data, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// Shares the registered-read instruction ROM between IFU fetch and LSU loads:
// LSU-first priority with an IFU starvation guard and fetch flush.
module rom_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input logic         clk,
  input logic         rst,
  rom_arbiter_if.slave bus
);

  typedef enum logic {PRIO_LS, PRIO_IF} prio_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_LS} tag_e;

  prio_e            state, state_nxt;
  tag_e             tag, tag_nxt;
  logic [CNT_W-1:0] starve_cnt, cnt_nxt;
  logic             win_if, win_ls;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRIO_LS;
      starve_cnt <= '0;
      tag        <= TAG_NONE;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
      tag        <= tag_nxt;
    end
  end

  // Promotion looks at the next count so IFU wins on the cycle right after its
  // STARVE_LIMIT-th denial.
  always_comb begin
    cnt_nxt   = starve_cnt;
    state_nxt = state;
    tag_nxt   = TAG_NONE;
    if (!bus.if_req || win_if || bus.flush)
      cnt_nxt = '0;
    else if (starve_cnt != CNT_W'(STARVE_LIMIT))
      cnt_nxt = starve_cnt + CNT_W'(1);
    case (state)
      PRIO_LS: if (cnt_nxt == CNT_W'(STARVE_LIMIT)) state_nxt = PRIO_IF;
      PRIO_IF: if (win_if || !bus.if_req || bus.flush) state_nxt = PRIO_LS;
      default: state_nxt = PRIO_LS;
    endcase
    if (win_if)
      tag_nxt = TAG_IF;
    else if (win_ls)
      tag_nxt = TAG_LS;
  end

  always_comb begin
    win_if       = !rst && bus.if_req && !bus.flush && (!bus.ls_req || state == PRIO_IF);
    win_ls       = !rst && bus.ls_req && !win_if;
    bus.if_gnt   = win_if;
    bus.ls_gnt   = win_ls;
    bus.rom_addr = '0;
    if (win_if)
      bus.rom_addr = bus.if_addr;
    else if (win_ls)
      bus.rom_addr = bus.ls_addr;
    bus.if_valid = !rst && tag == TAG_IF && !bus.flush;
    bus.ls_valid = !rst && tag == TAG_LS;
    bus.if_data  = bus.if_valid ? bus.rom_data : '0;
    bus.ls_data  = bus.ls_valid ? bus.rom_data : '0;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Vector/scoreboard bench for rom_arbiter with a behavioural registered-read ROM.
module tb_rom_arbiter;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_arbiter_if #(.XLEN(XLEN)) bus ();

  rom_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h5A00_0000 + (a >> 2) * 32'h0000_0101;
  endfunction

  always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic [31:0] ls_addr;
    logic        flush;
    logic        exp_if_gnt;
    logic        exp_ls_gnt;
  } vec_t;

  typedef struct {
    int          kind;   // 0 none, 1 IFU, 2 LSU
    logic [31:0] data;
  } resp_t;

  resp_t sb[$];
  vec_t  vecs[$];
  int    checks = 0;
  int    errors = 0;

  function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                              input logic lr, input logic [31:0] la, input logic fl,
                              input logic eig, input logic elg);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_addr = la;
    v.flush = fl; v.exp_if_gnt = eig; v.exp_ls_gnt = elg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    resp_t       e, n;
    logic [31:0] exp_addr;
    rst         = v.rst;
    bus.if_req  = v.if_req;
    bus.if_addr = v.if_addr;
    bus.ls_req  = v.ls_req;
    bus.ls_addr = v.ls_addr;
    bus.flush   = v.flush;
    @(negedge clk);
    e.kind = 0; e.data = '0;
    if (sb.size() != 0) e = sb.pop_front();
    if (v.rst || (e.kind == 1 && v.flush)) e.kind = 0;
    check("if_valid", 32'(bus.if_valid), 32'(e.kind == 1));
    check("if_data",  bus.if_data, e.kind == 1 ? e.data : 32'h0);
    check("ls_valid", 32'(bus.ls_valid), 32'(e.kind == 2));
    check("ls_data",  bus.ls_data, e.kind == 2 ? e.data : 32'h0);
    check("if_gnt",   32'(bus.if_gnt), 32'(v.exp_if_gnt));
    check("ls_gnt",   32'(bus.ls_gnt), 32'(v.exp_ls_gnt));
    exp_addr = v.exp_if_gnt ? v.if_addr : v.exp_ls_gnt ? v.ls_addr : 32'h0;
    check("rom_addr", bus.rom_addr, exp_addr);
    n.kind = v.exp_if_gnt ? 1 : v.exp_ls_gnt ? 2 : 0;
    n.data = rom_word(exp_addr);
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bus.if_req = 1'b0; bus.if_addr = '0; bus.ls_req = 1'b0;
    bus.ls_addr = '0; bus.flush = 1'b0;
    @(posedge clk); #1;

    //            rst ir  if_addr     lr  ls_addr     fl  eif els
    vecs.push_back(mk(1, 0, 32'h0,     0, 32'h0,     0, 0, 0));
    // sequential fetch 0,4,8
    vecs.push_back(mk(0, 1, 32'h0,     0, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h4,     0, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h8,     0, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,     0, 0, 0));
    // contention: LSU first, IFU after ls_req drops
    vecs.push_back(mk(0, 1, 32'h0,     1, 32'h10,    0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h0,     0, 32'h0,     0, 1, 0));
    // alternating back-to-back grants
    vecs.push_back(mk(0, 0, 32'h0,     1, 32'h44,    0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h48,    0, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,     1, 32'hFFFC,  0, 0, 1));
    // flush kills in-flight IFU response and the IFU grant
    vecs.push_back(mk(0, 1, 32'h20,    0, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h24,    1, 32'h30,    1, 0, 1));
    vecs.push_back(mk(0, 1, 32'h24,    0, 32'h0,     1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,     0, 0, 0));
    // reset right after an IFU grant drops its response
    vecs.push_back(mk(0, 1, 32'h60,    0, 32'h0,     0, 1, 0));
    vecs.push_back(mk(1, 1, 32'h64,    1, 32'h68,    0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h64,    1, 32'h68,    0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,     0, 0, 0));
    foreach (vecs[i]) step(vecs[i]);

    // starvation guard: four denials, IFU wins the fifth, LSU priority resumes
    for (int i = 0; i < 4; i++)
      step(mk(0, 1, 32'h100, 1, 32'h200 + 32'(i) * 4, 0, 0, 1));
    step(mk(0, 1, 32'h100, 1, 32'h210, 0, 1, 0));
    step(mk(0, 1, 32'h104, 1, 32'h210, 0, 0, 1));
    // a denial interrupted by if_req dropping restarts the count
    step(mk(0, 1, 32'h104, 1, 32'h214, 0, 0, 1));
    step(mk(0, 0, 32'h0,   1, 32'h218, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      step(mk(0, 1, 32'h108, 1, 32'h300 + 32'(i) * 4, 0, 0, 1));
    step(mk(0, 1, 32'h108, 1, 32'h310, 0, 1, 0));
    step(mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 0));
    step(mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
